// File: rtl/pool_layer_seq.sv
// pool_layer_seq: sequential 2x2 / stride-2 pooling engine over C square
// feature maps held in word-addressed memory.
//
// One memory port is used at a time. Each output window costs four reads
// followed by one write. Addresses are walked incrementally (map, line and
// window pointers) so only one multiplier exists: N*N, formed once at start.
//
// Optional feature: define POOL_AVG_MODE_EN to honour cfg_mode (0 = max,
// 1 = floor average). Without it the block always max-pools and contains
// no averaging adder.
//
// Handshakes: a request (rd_req / wr_req) rises with its address (and data)
// and keeps all of them stable until the matching ack is sampled high on a
// rising edge; that edge completes the transfer. An ack seen while its
// request is low is ignored. rd_req and wr_req are never high together.
module pool_layer_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int SIZE_W = 6,
    parameter int CH_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIZE_W-1:0] cfg_size,
    input  logic [CH_W-1:0]   cfg_channels,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
    input  logic              cfg_mode,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched layer configuration
    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] half_q;
    logic [CH_W-1:0]   ch_q;
    logic [ADDR_W-1:0] nn_q;

    // Traversal indices and address pointers
    logic [SIZE_W-1:0] x_q, y_q;
    logic [CH_W-1:0]   c_q;
    logic [ADDR_W-1:0] map_q;    // first word of map c
    logic [ADDR_W-1:0] line_q;   // first word of source row 2y of map c
    logic [ADDR_W-1:0] win_q;    // top-left word of the current window
    logic [1:0]        phase_q;  // which of the four window reads is pending

    logic signed [DATA_W-1:0] max_q;

    // Combinational helpers
    logic                     degenerate;
    logic [2*SIZE_W-1:0]      nn_full;
    logic [ADDR_W-1:0]        size_a;
    logic [ADDR_W-1:0]        size2_a;
    logic                     last_x, last_y, last_c, last_win;
    logic [SIZE_W-1:0]        x_nxt, y_nxt;
    logic [CH_W-1:0]          c_nxt;
    logic [ADDR_W-1:0]        map_nxt, line_nxt, win_nxt;
    logic [ADDR_W-1:0]        rd_addr_nxt;
    logic signed [DATA_W-1:0] rd_s;
    logic signed [DATA_W-1:0] max_res;
    logic signed [DATA_W-1:0] pool_res;

`ifdef POOL_AVG_MODE_EN
    logic                     mode_q;
    logic signed [DATA_W+1:0] sum_q;
    logic signed [DATA_W+1:0] rd_ext;
    logic signed [DATA_W+1:0] sum_tot;
    logic signed [DATA_W+1:0] avg_shift;
`else
    logic unused_cfg_mode;
    assign unused_cfg_mode = cfg_mode;
`endif

    assign degenerate = (cfg_size < SIZE_W'(2)) || (cfg_channels == '0);
    assign nn_full    = cfg_size * cfg_size;
    assign size_a     = ADDR_W'(size_q);
    assign size2_a    = size_a << 1;

    assign last_x   = (x_q == half_q - SIZE_W'(1));
    assign last_y   = (y_q == half_q - SIZE_W'(1));
    assign last_c   = (c_q == ch_q - CH_W'(1));
    assign last_win = last_x && last_y && last_c;

    // Next window position and pointers, used when a write completes
    always_comb begin
        x_nxt    = x_q + SIZE_W'(1);
        y_nxt    = y_q;
        c_nxt    = c_q;
        map_nxt  = map_q;
        line_nxt = line_q;
        win_nxt  = win_q + ADDR_W'(2);
        if (last_x) begin
            x_nxt = '0;
            if (!last_y) begin
                y_nxt    = y_q + SIZE_W'(1);
                line_nxt = line_q + size2_a;
                win_nxt  = line_q + size2_a;
            end else begin
                y_nxt    = '0;
                c_nxt    = c_q + CH_W'(1);
                map_nxt  = map_q + nn_q;
                line_nxt = map_q + nn_q;
                win_nxt  = map_q + nn_q;
            end
        end
    end

    // Address of the read that follows the one completing now
    always_comb begin
        rd_addr_nxt = win_q + ADDR_W'(1);
        case (phase_q)
            2'd0:    rd_addr_nxt = win_q + ADDR_W'(1);
            2'd1:    rd_addr_nxt = win_q + size_a;
            default: rd_addr_nxt = win_q + size_a + ADDR_W'(1);
        endcase
    end

    // Window reduction: running max, and floor average when built in
    assign rd_s    = $signed(rd_data);
    assign max_res = (rd_s > max_q) ? rd_s : max_q;

`ifdef POOL_AVG_MODE_EN
    assign rd_ext    = {{2{rd_data[DATA_W-1]}}, rd_data};
    assign sum_tot   = sum_q + rd_ext;
    assign avg_shift = sum_tot >>> 2;
    assign pool_res  = mode_q ? avg_shift[DATA_W-1:0] : max_res;
`else
    assign pool_res  = max_res;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = degenerate ? DONE : READ;
                end
            end
            READ: begin
                if (rd_ack && (phase_q == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    state_nxt = last_win ? DONE : READ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: configuration latch, pointers, accumulators, address/data regs
    always_ff @(posedge clk) begin
        if (reset) begin
            size_q  <= '0;
            half_q  <= '0;
            ch_q    <= '0;
            nn_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            map_q   <= '0;
            line_q  <= '0;
            win_q   <= '0;
            phase_q <= '0;
            max_q   <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
`ifdef POOL_AVG_MODE_EN
            mode_q  <= 1'b0;
            sum_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        size_q  <= cfg_size;
                        half_q  <= cfg_size >> 1;
                        ch_q    <= cfg_channels;
                        nn_q    <= ADDR_W'(nn_full);
                        x_q     <= '0;
                        y_q     <= '0;
                        c_q     <= '0;
                        map_q   <= cfg_src_base;
                        line_q  <= cfg_src_base;
                        win_q   <= cfg_src_base;
                        phase_q <= '0;
                        rd_addr <= cfg_src_base;
                        wr_addr <= cfg_dst_base;
`ifdef POOL_AVG_MODE_EN
                        mode_q  <= cfg_mode;
`endif
                    end
                end
                READ: begin
                    if (rd_ack) begin
                        phase_q <= phase_q + 2'd1;
                        if (phase_q == 2'd0) begin
                            max_q <= rd_s;
`ifdef POOL_AVG_MODE_EN
                            sum_q <= rd_ext;
`endif
                        end else begin
                            max_q <= max_res;
`ifdef POOL_AVG_MODE_EN
                            sum_q <= sum_tot;
`endif
                        end
                        if (phase_q == 2'd3) begin
                            wr_data <= pool_res;
                        end else begin
                            rd_addr <= rd_addr_nxt;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        x_q     <= x_nxt;
                        y_q     <= y_nxt;
                        c_q     <= c_nxt;
                        map_q   <= map_nxt;
                        line_q  <= line_nxt;
                        win_q   <= win_nxt;
                        rd_addr <= win_nxt;
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; busy also covers the cycle start is taken
    assign rd_req    = (state == READ);
    assign wr_req    = (state == WRITE);
    assign done      = (state == DONE);
    assign busy      = (state == READ) || (state == WRITE) ||
                       ((state == IDLE) && start && !reset);
    assign state_dbg = state;

endmodule

// File: tb/tb_pool_layer_seq.sv
// Bench for pool_layer_seq: memory model with programmable ack delay,
// reference pooling model feeding expected read/write queues, and a
// posedge monitor that pops and compares every completed transfer.
module tb_pool_layer_seq;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int SIZE_W = 6;
    localparam int CH_W   = 8;
`ifdef POOL_AVG_MODE_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SIZE_W-1:0] cfg_size;
    logic [CH_W-1:0]   cfg_channels;
    logic [ADDR_W-1:0] cfg_src_base;
    logic [ADDR_W-1:0] cfg_dst_base;
    logic              cfg_mode;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pool_layer_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_size(cfg_size), .cfg_channels(cfg_channels),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .cfg_mode(cfg_mode),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    logic [DATA_W-1:0] mem     [0:65535];
    logic [DATA_W-1:0] out_mem [0:65535];
    assign rd_data = mem[rd_addr];

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        exp_rd_q[$];
    int rd_delay = 0;
    int wr_delay = 0;
    int overlap_cnt = 0;
    int done_cnt = 0;
    int wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // memory ack driver: acks after rd_delay/wr_delay waiting cycles, noise while idle
    initial begin
        int rd_wait = 0;
        int wr_wait = 0;
        bit rd_xfer = 0;
        bit wr_xfer = 0;
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || rd_xfer) rd_wait = 0;
            if (reset || wr_xfer) wr_wait = 0;
            if (rd_req) begin
                if (rd_wait >= rd_delay) rd_ack = 1'b1;
                else begin rd_ack = 1'b0; rd_wait++; end
            end else begin
                rd_ack = 1'($urandom_range(0, 1));
            end
            if (wr_req) begin
                if (wr_wait >= wr_delay) wr_ack = 1'b1;
                else begin wr_ack = 1'b0; wr_wait++; end
            end else begin
                wr_ack = 1'($urandom_range(0, 1));
            end
            rd_xfer = rd_req && rd_ack;
            wr_xfer = wr_req && wr_ack;
        end
    end

    // scoreboard monitor: compares each completed transfer, checks held signals
    initial begin
        bit rd_held = 0;
        bit wr_held = 0;
        logic [ADDR_W-1:0] rd_held_addr = '0;
        logic [ADDR_W+DATA_W-1:0] wr_held_word = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                rd_held = 0;
                wr_held = 0;
            end else begin
                if (rd_req && wr_req) overlap_cnt++;
                if (done) done_cnt++;
                if (rd_req) begin
                    if (rd_held) check("rd_addr_stable", 32'(rd_addr), 32'(rd_held_addr));
                    if (rd_ack) begin
                        if (exp_rd_q.size() == 0) begin
                            n_checks++; n_errors++;
                            $display("FAIL rd_unexpected: read of %0h, no read expected", rd_addr);
                        end else begin
                            check("rd_addr_order", 32'(rd_addr), 32'(exp_rd_q.pop_front()));
                        end
                        rd_held = 0;
                    end else begin
                        rd_held = 1;
                        rd_held_addr = rd_addr;
                    end
                end else begin
                    rd_held = 0;
                end
                if (wr_req) begin
                    if (wr_held) check("wr_stable", {wr_addr, wr_data}, wr_held_word);
                    if (wr_ack) begin
                        out_mem[wr_addr] = wr_data;
                        wr_cnt++;
                        if (exp_q.size() == 0) begin
                            n_checks++; n_errors++;
                            $display("FAIL wr_unexpected: write %0h to %0h, no write expected", wr_data, wr_addr);
                        end else begin
                            check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
                        end
                        wr_held = 0;
                    end else begin
                        wr_held = 1;
                        wr_held_word = {wr_addr, wr_data};
                    end
                end else begin
                    wr_held = 0;
                end
            end
        end
    end

    // reference model: expected read order and results from the pooling rules
    task automatic build_expect(input int n, input int ch, input logic [ADDR_W-1:0] src,
                                input logic [ADDR_W-1:0] dst, input logic mode);
        int m;
        m = (n < 2 || ch == 0) ? 0 : n / 2;
        for (int c = 0; c < ch; c++)
            for (int y = 0; y < m; y++)
                for (int x = 0; x < m; x++) begin
                    int v[4];
                    int r;
                    int s;
                    logic [ADDR_W-1:0] da;
                    for (int k = 0; k < 4; k++) begin
                        logic [ADDR_W-1:0] a;
                        a = src + ADDR_W'(c * n * n + (2 * y + k / 2) * n + 2 * x + k % 2);
                        exp_rd_q.push_back(a);
                        v[k] = int'($signed(mem[a]));
                    end
                    if (mode && AVG_EN) begin
                        s = v[0] + v[1] + v[2] + v[3];
                        r = (s >= 0) ? s / 4 : -((-s + 3) / 4);
                    end else begin
                        r = v[0];
                        for (int k = 1; k < 4; k++) if (v[k] > r) r = v[k];
                    end
                    da = dst + ADDR_W'(c * m * m + y * m + x);
                    exp_q.push_back({da, DATA_W'(r)});
                end
    endtask

    task automatic load_seq(input logic [ADDR_W-1:0] base, input int count);
        for (int i = 0; i < count; i++) mem[base + ADDR_W'(i)] = DATA_W'(i);
    endtask

    task automatic load_rand(input logic [ADDR_W-1:0] base, input int count);
        for (int i = 0; i < count; i++) mem[base + ADDR_W'(i)] = DATA_W'($urandom);
    endtask

    // driver: run one layer and check its timing and completeness
    task automatic run_layer(input int n, input int ch, input logic [ADDR_W-1:0] src,
                             input logic [ADDR_W-1:0] dst, input logic mode,
                             input int rdd, input int wrd, input bit lat);
        int m;
        int cyc;
        int busy_cnt;
        int exp_cyc;
        m = n / 2;
        exp_cyc = (n < 2 || ch == 0) ? 1 : 5 * ch * m * m + 1;
        build_expect(n, ch, src, dst, mode);
        rd_delay = rdd;
        wr_delay = wrd;
        @(negedge clk);
        cfg_size     = SIZE_W'(n);
        cfg_channels = CH_W'(ch);
        cfg_src_base = src;
        cfg_dst_base = dst;
        cfg_mode     = mode;
        start        = 1'b1;
        #1;
        check("busy_on_start", 32'(busy), 32'd1);
        @(posedge clk);
        cyc = 0;
        busy_cnt = 1;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (!done && busy) busy_cnt++;
        end while (!done && cyc < 5000);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        if (lat) begin
            check("done_cycle", 32'(cyc), 32'(exp_cyc));
            check("busy_cycles", 32'(busy_cnt), 32'(exp_cyc));
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(state_dbg), 32'd0);
        check("wr_remaining", 32'(exp_q.size()), 32'd0);
        check("rd_remaining", 32'(exp_rd_q.size()), 32'd0);
        check("req_overlap", 32'(overlap_cnt), 32'd0);
        exp_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        check({tag, "_wr_req"}, 32'(wr_req), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        int wr_base;
        int done_base;
        int guard;
        reset        = 1'b1;
        start        = 1'b0;
        cfg_size     = '0;
        cfg_channels = '0;
        cfg_src_base = '0;
        cfg_dst_base = '0;
        cfg_mode     = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 4x4 ramp, one map, max pool, acks tied high
        load_seq(16'd0, 16);
        run_layer(4, 1, 16'd0, 16'd100, 1'b0, 0, 0, 1'b1);
        check("ramp_out0", 32'(out_mem[100]), 32'd5);
        check("ramp_out1", 32'(out_mem[101]), 32'd7);
        check("ramp_out2", 32'(out_mem[102]), 32'd13);
        check("ramp_out3", 32'(out_mem[103]), 32'd15);

        // odd edge: trailing row/column skipped, map 1 output at dst+4
        load_rand(16'd200, 50);
        run_layer(5, 2, 16'd200, 16'd1000, 1'b0, 0, 0, 1'b1);

        // degenerate layers
        run_layer(4, 0, 16'd0, 16'd2000, 1'b0, 0, 0, 1'b1);
        run_layer(1, 3, 16'd0, 16'd2000, 1'b0, 0, 0, 1'b1);

        // slow memory: 3-cycle ack delay on both ports
        run_layer(4, 1, 16'd0, 16'd300, 1'b0, 3, 3, 1'b0);
        check("slow_out0", 32'(out_mem[300]), 32'd5);
        check("slow_out3", 32'(out_mem[303]), 32'd15);

        // source wrapping past the top of the address space
        load_rand(16'hFFF8, 16);
        run_layer(4, 1, 16'hFFF8, 16'h4000, 1'b0, 1, 0, 1'b0);

        // average-mode windows (max pool expected when the feature is absent)
        mem[500] = -16'sd1; mem[501] = -16'sd2; mem[502] = -16'sd3; mem[503] = -16'sd3;
        mem[504] = 16'd1;   mem[505] = 16'd1;   mem[506] = 16'd1;   mem[507] = 16'd2;
        run_layer(2, 2, 16'd500, 16'd600, 1'b1, 0, 0, 1'b1);

        // reset during the second window of the ramp layer
        load_seq(16'd0, 16);
        build_expect(4, 1, 16'd0, 16'd100, 1'b0);
        rd_delay = 0;
        wr_delay = 0;
        wr_base = wr_cnt;
        done_base = done_cnt;
        @(negedge clk);
        cfg_size = 6'd4; cfg_channels = 8'd1; cfg_src_base = 16'd0;
        cfg_dst_base = 16'd100; cfg_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (wr_cnt == wr_base && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("abort_first_write_seen", 32'(wr_cnt - wr_base), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("abort");
        reset = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(done_base));
        check("abort_idle", 32'(state_dbg), 32'd0);
        run_layer(4, 1, 16'd0, 16'd100, 1'b0, 0, 0, 1'b1);

        // randomized layers
        for (int t = 0; t < 8; t++) begin
            int n;
            int ch;
            int rdd;
            int wrd;
            logic [ADDR_W-1:0] src;
            logic [ADDR_W-1:0] dst;
            n   = $urandom_range(2, 9);
            ch  = $urandom_range(1, 3);
            rdd = $urandom_range(0, 2);
            wrd = $urandom_range(0, 2);
            src = ADDR_W'($urandom_range(0, 16'h3FFF));
            dst = 16'h8000 + ADDR_W'($urandom_range(0, 16'h3FFF));
            load_rand(src, n * n * ch);
            run_layer(n, ch, src, dst, 1'($urandom_range(0, 1)), rdd, wrd,
                      (rdd == 0) && (wrd == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
